// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer in front of an SPI mode-0 byte engine. One accepted start
// runs a frame of NBYTES bytes to slave ch_sel. The controller drives the
// slave's chip select, hands each byte to the engine, collects the received
// bytes, and publishes the complete frame on data_out with a frame_done pulse.
// It supports single-shot or continuous frames, an inter-byte gap with CS held
// low, and a timeout on the engine handshake.
//
// Byte-engine handshake: get_byte is a request that stays high until the
// engine answers with busy=1. The controller then drops get_byte and waits for
// busy=0. The cycle after busy falls, data_rx is captured. data_send is only
// meaningful while get_byte is high, and reads 0 otherwise.
//
// Ports
//   clk, rst       system clock; asynchronous active-high reset
//   start, cont    level start request; 1 = continuous frames while start held
//   ch_sel         slave index (latched at frame start)
//   tx_frame       bytes to send, byte 0 in the MSBs (latched at frame start)
//   busy, data_rx  byte engine status and last received byte
//   get_byte       byte request to the engine
//   data_send      byte presented to the engine
//   cs_n           active-low chip selects, at most one low
//   data_out       last complete received frame, byte 0 in the MSBs
//   frame_done     one-cycle pulse when data_out updates
//   ctrl_busy      high whenever the sequencer is not idle
//   err            sticky error (bad ch_sel or timeout), cleared by next start
//   dbg_state      current FSM state (IDLE=0, REQ=1, WAIT=2, CAPT=3, GAP=4, DONE=5)
// ----------------------------------------------------------------------------
module spi_frame_ctrl #(
    parameter int NBYTES     = 5,
    parameter int NCS        = 2,
    parameter int CH_W       = 1,
    parameter int GAP_CYCLES = 10,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [8*NBYTES-1:0]   tx_frame,
    input  logic                  busy,
    input  logic [7:0]            data_rx,
    output logic                  get_byte,
    output logic [7:0]            data_send,
    output logic [NCS-1:0]        cs_n,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  frame_done,
    output logic                  ctrl_busy,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam int        FW    = 8 * NBYTES;
    localparam int        TMR_W = 16;
    localparam logic [3:0] LAST = 4'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [FW-1:0]     tx_q, tx_d;
    logic [FW-1:0]     shift_q, shift_d;
    logic [FW-1:0]     dout_q, dout_d;
    logic              err_q, err_d;
    // hold_q: already spent the first DONE cycle (frame_done only once).
    logic              hold_q, hold_d;
    // lock_q: a single-shot timeout happened; start must drop before retry.
    logic              lock_q, lock_d;

    logic              ch_ok;
    logic [6:0]        sh_amt;
    logic [NCS-1:0]    cs_sel;
    logic [FW-1:0]     shift_ins;
    logic              tmo_hit;

    assign ch_ok     = int'(ch_sel) < NCS;
    // Byte cnt lives at bit offset 8*(NBYTES-1-cnt) so that byte 0 is the MSBs.
    assign sh_amt    = 7'(8 * (NBYTES - 1 - int'(cnt_q)));
    assign cs_sel    = ~(NCS'(1) << ch_q);
    assign shift_ins = (shift_q & ~(FW'(8'hFF) << sh_amt)) | (FW'(data_rx) << sh_amt);
    // The timer holds the number of completed cycles in the current state,
    // so this fires at the end of the TIMEOUT-th cycle spent in REQ/WAIT.
    assign tmo_hit   = tmr_q == TMR_W'(TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        err_d      = err_q;
        lock_d     = lock_q;
        hold_d     = 1'b0;
        get_byte   = 1'b0;
        data_send  = 8'h00;
        cs_n       = '1;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!start) begin
                    lock_d = 1'b0;
                end else if (!lock_q) begin
                    if (ch_ok) begin
                        ch_d    = ch_sel;
                        tx_d    = tx_frame;
                        err_d   = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cs_n      = cs_sel;
                get_byte  = 1'b1;
                data_send = 8'(tx_q >> sh_amt);
                // busy wins over a timeout reached in the same cycle.
                if (busy) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    lock_d  = !cont;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cs_n = cs_sel;
                if (!busy) begin
                    state_d = S_CAPT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    lock_d  = !cont;
                    state_d = S_IDLE;
                end
            end
            S_CAPT: begin
                cs_n    = cs_sel;
                shift_d = shift_ins;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    dout_d  = shift_ins;
                    state_d = S_DONE;
                end else if (GAP_CYCLES == 0) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cs_n = cs_sel;
                if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                frame_done = !hold_q;
                // Single shot with start still high parks here until it drops.
                if (start && !cont) begin
                    hold_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tmr_q != '1) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = tmr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            ch_q    <= '0;
            tx_q    <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            ch_q    <= ch_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            lock_q  <= lock_d;
        end
    end

    assign data_out  = dout_q;
    assign err       = err_q;
    assign ctrl_busy = state_q != S_IDLE;
    assign dbg_state = state_q;

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Parametrised SPI frame sequencer that sits between the system logic and the SPI mode-0 byte engine. It runs one transaction of NBYTES bytes to one of NCS slaves: it selects the slave's chip select, hands each byte to the byte engine, gathers the received bytes into a frame register, and reports completion. It adds single-shot and continuous modes, an inter-byte gap and a handshake timeout, for joystick-class and similar peripherals.

Parameters:
NBYTES, 5, bytes per frame (1..15)
NCS, 2, number of slave chip selects (1..4)
CH_W, 1, width of ch_sel; must satisfy 2**CH_W >= NCS
GAP_CYCLES, 10, clk cycles CS stays low between bytes (0..255)
TIMEOUT, 1023, max clk cycles waiting for any busy edge before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  level request; sampled in IDLE
cont  in  1  1 = continuous frames while start held; 0 = single shot
ch_sel  in  CH_W  slave index, latched at frame start
tx_frame  in  8*NBYTES  bytes to send; byte 0 = MSBs, latched at frame start
busy  in  1  byte engine busy
data_rx  in  8  last byte received by the byte engine
get_byte  out  1  byte-transfer request to the engine
data_send  out  8  byte presented to the engine
cs_n  out  NCS  active-low chip selects, at most one low
data_out  out  8*NBYTES  last complete received frame, byte 0 = MSBs
frame_done  out  1  one-cycle pulse when data_out updates
ctrl_busy  out  1  high in every state except IDLE
err  out  1  sticky error flag; cleared at next accepted start

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, cs_n all 1, get_byte=0, data_send=0, data_out=0, frame_done=0, err=0, byte counter=0, gap/timeout counters=0. A reset mid-frame releases CS in the same instant. No partial frame reaches data_out.
- States: IDLE, REQ, WAIT, CAPT, GAP, DONE.
- IDLE: if start=1 and ch_sel<NCS, latch ch_sel and tx_frame, clear err and byte counter, go to REQ. If start=1 and ch_sel>=NCS, set err, no CS activity, stay in IDLE.
- REQ: cs_n[ch]=0, get_byte=1, data_send=byte[cnt]. Stay until busy=1, then go to WAIT with get_byte=0 next cycle. The timeout counter runs here.
- WAIT: get_byte=0, cs low. When busy=0, go to CAPT. The timeout counter runs here.
- CAPT (one cycle): store data_rx into shift register byte[cnt] and increment cnt. If cnt reaches NBYTES, go to DONE. Otherwise go to GAP, or straight to REQ if GAP_CYCLES=0.
- GAP: CS held low for exactly GAP_CYCLES cycles, then go to REQ.
- DONE (one cycle): cs_n all 1, data_out=shift register, frame_done=1. Then:
  - if cont=1 and start=1, return to IDLE and restart next cycle, giving at least 2 cycles of CS high between frames;
  - if cont=0, wait in DONE-hold (still DONE, frame_done=0 after the first cycle) until start=0, then go to IDLE.
- Timeout: the counter resets on every state entry. If it reaches TIMEOUT in REQ or WAIT: set err, release CS, get_byte=0, keep data_out unchanged, no frame_done, go to IDLE (start must fall before retry in single-shot mode).
- Latency, ideal engine: from start to the first get_byte is 1 cycle. frame_done comes one cycle after the last CAPT.
- Simultaneous events: busy rising in the same cycle the timeout terminal count is reached counts as success. Changes to ch_sel or tx_frame mid-frame are ignored.
- The byte counter width is 4 bits. NBYTES=1 gives no GAP state.

Test Plan:
- NBYTES=5, ch_sel=0, tx_frame=0x8000000000, engine model returns 0x11,0x22,0x33,0x44,0x55 -> data_out=0x1122334455, frame_done one pulse, cs_n=2'b10 throughout, data_send sequence 0x80,0,0,0,0.
- GAP_CYCLES=10 -> CS stays low between bytes and get_byte rising edges are spaced exactly (engine time + 1 + 10 + 1) cycles apart.
- cont=1, start held, 3 frames -> 3 frame_done pulses, CS high for at least 2 cycles between frames; cont=0 -> exactly one frame until start drops.
- ch_sel=3 with NCS=2 -> err=1, cs_n stays 2'b11, get_byte never asserts; next valid start clears err.
- Engine busy stuck 0 -> err set after TIMEOUT cycles in REQ, CS released, data_out keeps its previous value.
- Assert rst during byte 3 -> cs_n=all 1 and get_byte=0 immediately, data_out=0, the next frame completes normally.
